// File: rtl/mem_pkg.sv
// Memory-access types shared by the store shifter and the load aligner.
// Size encoding matches the CPU's 2-bit size field; SIZE_BAD is never a legal access.
package mem_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE,
        SIZE_HALF,
        SIZE_WORD,
        SIZE_BAD
    } access_size_t;

    function automatic logic [2:0] size_bytes(access_size_t sz);
        case (sz)
            SIZE_BYTE: return 3'd1;
            SIZE_HALF: return 3'd2;
            SIZE_WORD: return 3'd4;
            default:   return 3'd0;
        endcase
    endfunction

    // An access crosses a word boundary when its last byte lands in the next word.
    function automatic logic crosses_word(logic [1:0] offset, access_size_t sz);
        return ({1'b0, offset} + size_bytes(sz)) > 3'd4;
    endfunction

endpackage

// File: rtl/load_extractor.sv
// Combinational byte extraction: picks the addressed bytes out of a {hi,lo} word pair
// and right-aligns them with sign or zero extension.
module load_extractor
    import mem_pkg::*;
(
    input  logic [31:0]  i_lo,
    input  logic [31:0]  i_hi,
    input  logic [1:0]   i_offset,
    input  access_size_t i_size,
    input  logic         i_signed,
    output logic [31:0]  o_data
);

    logic [31:0] w_shifted;

    // Little-endian: the byte at the load address ends up in bits [7:0].
    assign w_shifted = 32'({i_hi, i_lo} >> {i_offset, 3'b000});

    always_comb begin
        o_data = '0;
        case (i_size)
            SIZE_BYTE: o_data = {{24{i_signed & w_shifted[7]}}, w_shifted[7:0]};
            SIZE_HALF: o_data = {{16{i_signed & w_shifted[15]}}, w_shifted[15:0]};
            SIZE_WORD: o_data = w_shifted;
            default:   o_data = '0;
        endcase
    end

endmodule

// File: rtl/load_aligner.sv
// CPU load path to word bus: issues one or two aligned reads per load and returns
// the aligned, extended result. Handshake: cpu_req is taken only while cpu_ready=1,
// bus_rd stays high until bus_ack, and cpu_done pulses once per accepted load.
module load_aligner
    import mem_pkg::*;
#(
    parameter int unsigned ALLOW_MISALIGNED = 1,
    parameter int unsigned TIMEOUT_CYCLES   = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    output logic        cpu_ready,
    input  logic [31:0] cpu_addr,
    input  logic [1:0]  cpu_size,
    input  logic        cpu_signed,
    output logic        cpu_done,
    output logic [31:0] cpu_data,
    output logic        cpu_error,
    output logic        bus_rd,
    output logic [31:0] bus_addr,
    input  logic        bus_ack,
    input  logic [31:0] bus_data,
    output logic [1:0]  o_dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ_LO,
        ST_READ_HI,
        ST_RESP
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [1:0]   r_offset;
    access_size_t r_size;
    logic         r_signed;
    logic [31:0]  r_lo;
    logic [31:0]  r_bus_addr;
    logic [31:0]  r_tmo_cnt;
    logic [31:0]  r_data;
    logic         r_err;

    access_size_t w_req_size;
    logic         w_req_bad;
    logic         w_accept;
    logic         w_crossing;
    logic         w_expire;
    logic         w_load_resp;
    logic         w_resp_err;
    logic         w_start_hi;
    logic [31:0]  w_lo;
    logic [31:0]  w_ext_data;

    assign w_req_size = access_size_t'(cpu_size);
    assign w_req_bad  = (w_req_size == SIZE_BAD) ||
                        ((ALLOW_MISALIGNED == 0) && crosses_word(cpu_addr[1:0], w_req_size));
    assign w_accept   = (r_state == ST_IDLE) && cpu_req;
    assign w_crossing = crosses_word(r_offset, r_size);
    assign w_expire   = (TIMEOUT_CYCLES != 0) && (r_tmo_cnt == TIMEOUT_CYCLES - 1);

    // Single-read loads extract straight from the bus word; split loads pair it with r_lo.
    assign w_lo = (r_state == ST_READ_LO) ? bus_data : r_lo;

    load_extractor u_extractor (
        .i_lo     (w_lo),
        .i_hi     (bus_data),
        .i_offset (r_offset),
        .i_size   (r_size),
        .i_signed (r_signed),
        .o_data   (w_ext_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // An ack always beats a timeout expiring in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_load_resp = 1'b0;
        w_resp_err  = 1'b0;
        w_start_hi  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cpu_req) begin
                    if (w_req_bad) begin
                        w_state_nxt = ST_RESP;
                        w_load_resp = 1'b1;
                        w_resp_err  = 1'b1;
                    end else begin
                        w_state_nxt = ST_READ_LO;
                    end
                end
            end
            ST_READ_LO: begin
                if (bus_ack) begin
                    if (w_crossing) begin
                        w_state_nxt = ST_READ_HI;
                        w_start_hi  = 1'b1;
                    end else begin
                        w_state_nxt = ST_RESP;
                        w_load_resp = 1'b1;
                    end
                end else if (w_expire) begin
                    w_state_nxt = ST_RESP;
                    w_load_resp = 1'b1;
                    w_resp_err  = 1'b1;
                end
            end
            ST_READ_HI: begin
                if (bus_ack) begin
                    w_state_nxt = ST_RESP;
                    w_load_resp = 1'b1;
                end else if (w_expire) begin
                    w_state_nxt = ST_RESP;
                    w_load_resp = 1'b1;
                    w_resp_err  = 1'b1;
                end
            end
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_offset   <= '0;
            r_size     <= SIZE_BYTE;
            r_signed   <= 1'b0;
            r_lo       <= '0;
            r_bus_addr <= '0;
            r_tmo_cnt  <= '0;
            r_data     <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_offset <= cpu_addr[1:0];
                r_size   <= w_req_size;
                r_signed <= cpu_signed;
            end
            // The +4 wraps naturally at the top of the address space.
            if (w_accept && !w_req_bad) r_bus_addr <= {cpu_addr[31:2], 2'b00};
            else if (w_start_hi)        r_bus_addr <= r_bus_addr + 32'd4;
            if ((r_state == ST_READ_LO) && bus_ack) r_lo <= bus_data;
            if ((w_accept && !w_req_bad) || w_start_hi) r_tmo_cnt <= '0;
            else if (bus_rd && (TIMEOUT_CYCLES != 0))   r_tmo_cnt <= r_tmo_cnt + 32'd1;
            if (w_load_resp) begin
                r_data <= w_resp_err ? '0 : w_ext_data;
                r_err  <= w_resp_err;
            end
        end
    end

    assign cpu_ready   = (r_state == ST_IDLE);
    assign cpu_done    = (r_state == ST_RESP);
    assign cpu_data    = r_data;
    assign cpu_error   = r_err;
    assign bus_rd      = (r_state == ST_READ_LO) || (r_state == ST_READ_HI);
    assign bus_addr    = r_bus_addr;
    assign o_dbg_state = r_state;

endmodule
